rv_fetch_unit: RTL

//  Parametrised RV32I instruction-fetch stage: byte-addressed PC (+4 per fetch), sync-read instruction BRAM

---
 rtl/rv_pkg.sv | 31 +++
 rtl/imem_bram.sv | 41 ++++
 rtl/rv_fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I constants and types for the fetch stage.
//   - RV32I major opcode values (bits [6:0] of an instruction)
//   - INST_NOP / INST_EBREAK encodings
//   - fetch_state_t: fetch FSM state encoding
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  function automatic logic is_ebreak(input logic [31:0] inst);
    return inst == INST_EBREAK;
  endfunction

endpackage

// File: rtl/imem_bram.sv
// imem_bram: single-clock instruction BRAM, one write port and one
// synchronous read port with read enable. Read-first: a read and a write to
// the same word on the same edge return the word's previous contents.
// The read-data register holds its value while re is low and resets to NOP.
// Ports:
//   CLK, RESET      clock, async active-high reset (read register only)
//   we/waddr/wdata  program-load write port
//   re/raddr        read enable and word address
//   rdata           registered read data
module imem_bram
  import rv_pkg::*;
#(
  parameter  int MEM_WORDS = 256,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // NOTE: the array has no reset so it maps onto block RAM; program contents
  // survive RESET by design.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Both blocks sample on the same edge with non-blocking updates, so this
  // read sees the pre-write word (read-first).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   rdata <= INST_NOP;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I instruction-fetch stage.
// Byte-addressed fetch PC (npc, +4 per issued read) driving a synchronous
// instruction BRAM; the BRAM read register is the instruction output.
// Valid/ready handshake to decode, redirect (branch/jump) with flush, and an
// EBREAK halt that waits for resume_i.
// Ports:
//   CLK, RESET                         clock, async active-high reset
//   imem_we/imem_waddr/imem_wdata      program-load port into the BRAM
//   ready_i / valid_o                  decode handshake
//   inst_o / pc_o                      instruction and its byte address
//   redirect_i / redirect_pc_i         flush and refetch from new PC
//   resume_i / halted_o                leave HALT / fetch is halted
//   fetch_count_o                      accepted-instruction counter
// Configuration: define RV_FETCH_PERF_EN to build the fetch_count_o counter;
// otherwise fetch_count_o is tied to zero.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter  int              XLEN      = 32,
  parameter  int              MEM_WORDS = 256,
  parameter  logic [XLEN-1:0] RESET_PC  = '0,
  localparam int              AW        = $clog2(MEM_WORDS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            imem_we,
  input  logic [AW-1:0]   imem_waddr,
  input  logic [31:0]     imem_wdata,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            resume_i,
  output logic            halted_o,
  output logic [31:0]     fetch_count_o
);

  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_t    state;
  logic [XLEN-1:0] npc;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic            halted_q;
  logic [31:0]     inst;

  logic            accept;
  logic            hold_ebreak;
  logic            issue;
  logic [XLEN-1:0] redirect_target;

  // An EBREAK sitting on the output blocks further reads, so npc already
  // equals ebreak pc + 4 when it is accepted and the halt begins.
  assign accept          = valid_q && ready_i;
  assign hold_ebreak     = valid_q && is_ebreak(inst);
  assign issue           = (state == ST_RUN) && (!valid_q || ready_i) &&
                           !redirect_i && !hold_ebreak;
  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

  imem_bram #(.MEM_WORDS(MEM_WORDS)) u_imem (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .re    (issue),
    .raddr (npc[AW+1:2]),
    .rdata (inst)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      npc      <= START_PC;
      valid_q  <= 1'b0;
      pc_q     <= START_PC;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_RUN: begin
          // A redirect squashes the instruction on the output, EBREAK included.
          if (!redirect_i && accept && hold_ebreak) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume_i) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (redirect_i)  npc <= redirect_target;
      else if (issue)  npc <= npc + XLEN'(4);

      if (redirect_i) begin
        valid_q <= 1'b0;
      end else if (issue) begin
        valid_q <= 1'b1;
        pc_q    <= npc;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o  = valid_q;
  assign inst_o   = inst;
  assign pc_o     = pc_q;
  assign halted_o = halted_q;

`ifdef RV_FETCH_PERF_EN
  logic [31:0] fetch_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       fetch_count <= '0;
    else if (accept) fetch_count <= fetch_count + 32'd1;
  end

  assign fetch_count_o = fetch_count;
`else
  assign fetch_count_o = '0;
`endif

  // Byte-offset bits of the redirect target and PC bits above the BRAM index
  // do not select anything in memory.
  logic unused_bits;
  assign unused_bits = ^{redirect_pc_i[1:0], npc[XLEN-1:AW+2], npc[1:0]};

endmodule
